// File: rtl/bdiv_pkg.sv
// rtl/bdiv_pkg.sv - widths, counter limit and FSM state type for the 52/26 restoring divider
package bdiv_pkg;
  localparam int DIVD_W = 52;
  localparam int DIVS_W = 26;
  localparam int QUO_W  = 26;
  localparam int CNT_W  = 5;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QUO_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } bdiv_state_t;
endpackage

// File: rtl/bdiv_step.sv
// rtl/bdiv_step.sv - one combinational restoring-division step: shift in a bit, conditionally subtract M
module bdiv_step
  import bdiv_pkg::*;
(
  input  logic [DIVS_W:0]   r,
  input  logic              bit_in,
  input  logic [DIVS_W-1:0] m,
  output logic [DIVS_W:0]   r_next,
  output logic              q_bit
);
  logic [DIVS_W:0] t;
  logic [DIVS_W:0] m_ext;

  assign t     = {r[DIVS_W-1:0], bit_in};
  assign m_ext = {1'b0, m};

  // r[26] set would mean the shifted value already exceeds any 26-bit M
  assign q_bit  = r[DIVS_W] | (t >= m_ext);
  assign r_next = q_bit ? (t - m_ext) : t;
endmodule

// File: rtl/bdiv52x26_seq.sv
// rtl/bdiv52x26_seq.sv - sequential 52/26 radix-2 restoring divider, one quotient bit per cycle
// BDIV52X26_REM_EN exposes the remainder on port R; otherwise it stays internal.
module bdiv52x26_seq
  import bdiv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DIVD_W-1:0] D,
  input  logic [DIVS_W-1:0] M,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [QUO_W-1:0]  Q,
`ifdef BDIV52X26_REM_EN
  output logic [DIVS_W-1:0] R,
`endif
  output logic              ovf
);
  bdiv_state_t       state;
  logic [CNT_W-1:0]  cnt;
  logic [DIVS_W:0]   r_q;
  logic [DIVS_W-1:0] sh_q;
  logic [DIVS_W-1:0] m_q;
  logic [DIVS_W:0]   step_r;
  logic              step_q;
  logic              ovf_n;

  assign ovf_n = (D[DIVD_W-1:DIVS_W] >= M);

  bdiv_step u_step (
    .r      (r_q),
    .bit_in (sh_q[DIVS_W-1]),
    .m      (m_q),
    .r_next (step_r),
    .q_bit  (step_q)
  );

`ifdef BDIV52X26_REM_EN
  assign R = r_q[DIVS_W-1:0];
`else
  // remainder lives only in r_q
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      Q         <= '0;
      ovf       <= 1'b0;
      cnt       <= '0;
      r_q       <= '0;
      sh_q      <= '0;
      m_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            m_q      <= M;
            sh_q     <= D[DIVS_W-1:0];
            ovf      <= ovf_n;
            if (ovf_n) begin
              // out_valid is raised one cycle later from DONE
              state <= DONE;
              Q     <= '1;
              r_q   <= {1'b0, D[DIVS_W-1:0]};
            end else begin
              state <= CALC;
              Q     <= '0;
              r_q   <= {1'b0, D[DIVD_W-1:DIVS_W]};
              cnt   <= CNT_LAST;
            end
          end
        end
        CALC: begin
          r_q  <= step_r;
          sh_q <= {sh_q[DIVS_W-2:0], 1'b0};
          Q    <= {Q[QUO_W-2:0], step_q};
          if (cnt == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/bdiv52x26_seq.md
# bdiv52x26_seq

Sequential radix-2 restoring divider that inverts a Bmult26x26 product: a 52-bit dividend is divided by a 26-bit divisor to give a 26-bit quotient and, optionally, a 26-bit remainder. It is used for modular reduction and product checking behind the 26x26 multiplier datapath in the crypto arithmetic library. It produces one quotient bit per cycle and uses valid/ready handshakes on both sides.

## Interface
- Parameters: none. Widths are fixed by package constants.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  dividend/divisor pair is valid.
- `in_ready`  out  1  block is idle and can accept a pair.
- `D`  in  52  dividend; sampled on the accept edge.
- `M`  in  26  divisor; sampled on the accept edge.
- `out_valid`  out  1  result is valid.
- `out_ready`  in  1  consumer takes the result.
- `Q`  out  26  quotient.
- `R`  out  26  remainder. This port exists only with `BDIV52X26_REM_EN`.
- `ovf`  out  1  quotient overflow: D[51:26] >= M, which includes M == 0.

## Operation
- FSM states: IDLE, CALC, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid && in_ready`, latch M. Latch partial remainder r = {1'b0, D[51:26]} (27 bits). Latch shift register = D[25:0].
  - Compute `ovf_n = (D[51:26] >= M)`.
  - If `ovf_n`, go to DONE. Otherwise go to CALC with the counter at 25.
- **CALC**: one step per edge.
  - t = {r[25:0], sh[25]}; shift `sh` left by 1.
  - If t >= {1'b0, M}: r = t − M, q bit = 1. Otherwise r = t, q bit = 0.
  - Shift the q bit into the quotient LSB.
  - When the counter reaches 0, go to DONE. Otherwise decrement it.
- **DONE**
  - `out_valid`=1. Q, R and `ovf` are held stable until the handshake.
  - On `out_valid && out_ready`, return to IDLE.
- Overflow result: Q = 26'h3FFFFFF, R = D[25:0], `ovf`=1.
- Normal result: `ovf`=0, Q·M + R == D, and R < M.
- No pipelining: `in_ready`=0 in CALC and in DONE. There is no same-cycle bypass from output handshake to input accept.
- Arithmetic: every compare and subtract is unsigned and 27 bits wide. The invariant r < M holds at every step, so the subtraction never underflows.

## Timing
- Reset (sync, `rst`=1 at an edge):
  - State goes to IDLE.
  - `out_valid`=0, Q=0, R=0, `ovf`=0, counter=0.
  - While `rst` is high, `in_ready`=0.
  - `in_ready`=1 in the first cycle after the first edge with `rst`=0.
- Reset mid-CALC or mid-DONE: the result is discarded and `out_valid` never asserts for that operation.
- Latency, counted from accept edge E:
  - Normal case: `out_valid` rises after edge E+26, which is 26 cycles.
  - Overflow case: `out_valid` rises after edge E+1.
- Throughput with `out_ready` held at 1: one result every 28 cycles in the normal case, one every 3 cycles in overflow.
- Backpressure: DONE holds for any length of time. Outputs must not change until the handshake edge.
- Outputs are registered only. There is no combinational path from `in_valid`/`D`/`M` to any output, or from `out_ready` to `in_ready`.
- `in_valid` while `in_ready`=0 is ignored. It is not queued.

## Configuration
- `BDIV52X26_REM_EN` defined:
  - Port R is present.
  - R carries the final partial remainder r[25:0], or D[25:0] on overflow.
- `BDIV52X26_REM_EN` undefined:
  - Port R is absent.
  - The remainder register is kept internally because the algorithm needs it.
  - Q, `ovf` and timing are identical to the defined case.

## Structure
- Package `bdiv_pkg` holds:
  - `DIVD_W`=52, `DIVS_W`=26, `QUO_W`=26.
  - The FSM state enum `bdiv_state_t`.
  - Counter width `CNT_W`=5.
- Sub-module `bdiv_step` is purely combinational, one restoring step:
  - Inputs: r[26:0], the incoming bit, M.
  - Outputs: next r and the q bit.
- The top module owns the FSM, the counter, the shift registers and the handshakes.

## Test plan
- **Exact product**: D=83810205 (12345·6789), M=6789, `out_ready`=1.
  - Expect Q=12345, R=0, `ovf`=0.
  - `out_valid` rises exactly 26 cycles after the accept edge.
- **Small with remainder**: D=100, M=7.
  - Expect Q=14, R=2, `ovf`=0.
- **Max product**: D=52'hFFFFFF8000001, M=26'h3FFFFFF.
  - Expect Q=26'h3FFFFFF, R=0, `ovf`=0.
- **Divide by zero / overflow**:
  - M=0, D=5: `ovf`=1, Q=26'h3FFFFFF, R=5, `out_valid` 1 cycle after accept.
  - Also D={26'd10, 26'd0} with M=10: `ovf`=1.
- **Backpressure**: hold `out_ready`=0 for 10 cycles in DONE.
  - Q/R/`ovf` stay stable, `in_ready`=0, and a pulsed `in_valid` is ignored.
  - On release, the handshake completes and `in_ready`=1 in the next cycle.
- **Reset mid-CALC**: assert `rst` for 1 cycle, 10 cycles after accept.
  - `out_valid` stays 0, all outputs read 0, and `in_ready`=1 in the cycle after `rst` deasserts.
  - A new pair (100, 7) is then accepted and returns Q=14, R=2.
